// File: rtl/mem_pkg.sv
// ============================================================
// mem_pkg: shared funct3 codes, clear-FSM state and word width
// Rev 1.0
// ============================================================
`default_nettype none

package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================
// mem_lane_align: byte-lane steering, load extension, size checks
// Rev 1.0
// ============================================================
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              write_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] rword_i,
  output logic [3:0]        be_o,
  output logic [WORD_W-1:0] wword_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // funct3[2] marks the zero-extending loads; it is illegal on a store
  always_comb begin
    be_o         = 4'b0000;
    wword_o      = wdata_i;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o      = 4'b0001 << addr_lo_i;
        wword_o   = {4{wdata_i[7:0]}};
        rdata_o   = funct3_i[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        illegal_o = write_i && funct3_i[2];
      end
      F3_H, F3_HU: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o      = {2{wdata_i[15:0]}};
        rdata_o      = funct3_i[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        misaligned_o = addr_lo_i[0];
        illegal_o    = write_i && funct3_i[2];
      end
      F3_W: begin
        be_o         = 4'b1111;
        rdata_o      = rword_i;
        misaligned_o = |addr_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/byte_data_memory.sv
// ============================================================
// byte_data_memory: byte-addressable data RAM with clear engine
// Rev 1.0
// ============================================================
`default_nettype none

module byte_data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [AW-1:0]     req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(DEPTH - 1);

  mem_state_t        state_q, state_d;
  logic [IDXW-1:0]   clr_idx_q, clr_idx_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [IDXW-1:0]   w_idx;
  logic              w_oor, w_misaligned, w_illegal, w_err;
  logic              w_accept, w_store, w_clr_we;
  logic [3:0]        w_be;
  logic [WORD_W-1:0] w_wword, w_rword, w_rdata_ext;

  assign w_idx    = req_addr[IDXW+1:2];
  assign w_oor    = |req_addr[AW-1:IDXW+2];
  assign w_rword  = mem_q[w_idx];
  assign w_err    = w_oor | w_misaligned | w_illegal;
  assign w_accept = req_valid && req_ready;
  assign w_store  = w_accept && req_write && !w_err;

  mem_lane_align u_align (
    .funct3_i     (req_funct3),
    .addr_lo_i    (req_addr[1:0]),
    .write_i      (req_write),
    .wdata_i      (req_wdata),
    .rword_i      (w_rword),
    .be_o         (w_be),
    .wword_o      (w_wword),
    .rdata_o      (w_rdata_ext),
    .misaligned_o (w_misaligned),
    .illegal_o    (w_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + IDXW'(1);
        if (clr_idx_q == c_LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    req_ready = (state_q == IDLE) && !clear_req;
    w_clr_we  = (state_q == CLEAR);
  end

  // Storage has no reset; the clear engine is what zeroes it
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= w_accept;
      if (w_accept) begin
        rsp_err_q   <= w_err;
        rsp_rdata_q <= (w_err || req_write) ? '0 : w_rdata_ext;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: doc/byte_data_memory.md
# byte_data_memory

Parametrised byte-addressable data memory for the single-cycle and upcoming multi-cycle RISC-V cores. It adds these capabilities:
- sub-word loads and stores (byte/half/word, signed and unsigned) with byte-lane write enables;
- misalignment and range error reporting;
- a request/response handshake;
- a sequential clear engine that zeroes the array after reset or on request, replacing single-cycle bulk clear.

It sits between the core's load/store path and the array storage.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `AW`, 32: byte-address width.
- `IDXW`, `$clog2(DEPTH)`: derived word-index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clear_req`  in  1  pulse; restarts the clear engine.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V size/sign code.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `rsp_valid`  out  1  one-cycle response strobe, for both loads and stores.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and on error.
- `rsp_err`  out  1  misaligned, out-of-range or illegal `funct3`.
- `busy`  out  1  clear in progress.

## Operation
- States:
  - CLEAR: writes 0 to word `clr_idx`, increments `clr_idx`; at `clr_idx == DEPTH-1` it writes and moves to IDLE. Takes exactly `DEPTH` cycles.
  - IDLE: serves requests.
- Transitions:
  - `reset` asserted (low) → CLEAR with `clr_idx = 0`, from any state, including mid-clear; the engine restarts at 0.
  - `clear_req` in IDLE → CLEAR next cycle, `clr_idx = 0`.
  - `clear_req` during CLEAR is ignored.
- Ready and busy:
  - `req_ready = (state == IDLE) && !clear_req`; `clear_req` wins over a simultaneous request.
  - `busy = (state == CLEAR)`.
- Word index and range:
  - Word index = `req_addr[IDXW+1:2]`.
  - Out-of-range when any of `req_addr[AW-1:IDXW+2]` is nonzero.
- `funct3` codes: 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU. The codes 011, 110 and 111 are illegal. Unsigned codes with `req_write = 1` are illegal.
- Misaligned: H/HU with `addr[0] = 1`; W with `addr[1:0] != 0`.
- Any error: no array write, `rsp_rdata = 0`, `rsp_err = 1`.
- Store:
  - Byte lanes are selected by `addr[1:0]`. B writes lane `addr[1:0]` with `wdata[7:0]`; H writes lanes `{addr[1], 0}` and `{addr[1], 1}` with `wdata[15:0]`; W writes all 4 lanes.
  - Unselected lanes are unchanged.
- Load: selects the lane or half from the addressed word and right-aligns it. It then sign-extends (B/H) or zero-extends (BU/HU).

## Timing
- Accept in cycle N → `rsp_valid = 1` in cycle N+1 for exactly one cycle, with `rsp_rdata`/`rsp_err` valid. A back-to-back request in N+1 is allowed; throughput is 1 per cycle.
- Stores commit at the accepting edge. A load accepted in N+1 to the same word returns the stored data, with no stale read.
- No response back-pressure; the consumer must sample `rsp_*` in the strobe cycle.
- `rsp_rdata`/`rsp_err` hold their value until the next response. `rsp_valid` is registered.
- Reset values: `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`, `busy = 1`.
- Reset asserted while a response is pending: the response is dropped (`rsp_valid = 0`).
- After reset release: `busy` stays 1 for `DEPTH` cycles; `req_ready` first rises in cycle `DEPTH` (counting the first post-release edge as cycle 0).
- All reads during IDLE see the cleared contents (0) until they are written.

## Structure
- Package `mem_pkg`:
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state enum `mem_state_t {CLEAR, IDLE}`;
  - `WORD_W = 32`.
- Sub-module `mem_lane_align` (combinational) produces:
  - the 4-bit byte-enable and lane-shifted write word from `funct3`, `addr[1:0]` and `wdata`;
  - the extended load value from the read word;
  - the misaligned/illegal flags.
- The top level holds the array, the clear FSM and counter, the range check and the response register.

## Test plan
- Reset with `DEPTH = 16` → `busy = 1` for 16 cycles and `req_ready = 0`. Then `req_ready = 1`, and a `lw` of 0x3C returns 0, err 0.
- `sw 0x11223344` at 0x8, then back-to-back `lb`/`lbu`/`lh`/`lhu`/`lw`:
  - `lb` 0xB → 0x00000011;
  - `lbu` 0x8 → 0x00000044;
  - `lh` 0xA → 0x00001122;
  - `lw` 0x8 → 0x11223344.
- `sb 0x80` at 0x9 over 0x11223344, then `lw` 0x8 → 0x11228044. `lb` 0x9 → 0xFFFFFF80; `lbu` 0x9 → 0x00000080.
- `sh` at 0x3, `lw` at 0x6, `funct3` 011, and address 0x40 with `DEPTH = 16` → `rsp_err = 1` and `rsp_rdata = 0`. A subsequent `lw` shows memory is unchanged.
- `clear_req` together with `req_valid` (store) in IDLE → store not accepted, `busy` for 16 cycles, then all words read 0.
- `reset` pulsed at clear cycle 7, and `reset` pulsed the cycle after a load accept → clear restarts with a full 16 cycles, and the pending `rsp_valid` is suppressed.
